// File: rtl/conv_channel_sched.sv
// conv_channel_sched: walks the output channels of a Conv2d layer. For each
// channel it fetches the weight/bias pair from parameter memory, holds it on
// the Conv2d filter inputs for a fixed settle time, then offers the result to
// a downstream consumer through a valid/ready handshake.
module conv_channel_sched #(
    parameter int N      = 24,
    parameter int C      = 64,
    parameter int OUTCH  = 128,
    parameter int CHW    = 7,
    parameter int SETTLE = 5
) (
    input  logic                 clk,
    input  logic                 global_rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 p_rd_en,
    output logic [CHW-1:0]       p_rd_addr,
    input  logic [9*N*C-1:0]     p_rd_weight,
    input  logic [N-1:0]         p_rd_bias,
    output logic [9*N*C-1:0]     conv_weight,
    output logic [N-1:0]         conv_bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch
);

    localparam int WW   = 9 * N * C;
    // Counter only has to reach SETTLE-1; keep at least one bit.
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE - 1);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(OUTCH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CHW-1:0]  ch_r;
    logic [CHW-1:0]  ch_s;
    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] cnt_s;
    logic            load_s;

    logic            busy_r;
    logic            done_r;
    logic            p_rd_en_r;
    logic            out_valid_r;
    logic [WW-1:0]   conv_weight_r;
    logic [N-1:0]    conv_bias_r;

    // Next-state, channel and settle-counter decisions; abort beats everything
    // except reset, including a handshake landing on the same edge.
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            ch_s    = {CHW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // abort held together with start keeps the block idle
                    if (start && !abort) begin
                        state_s = ST_FETCH;
                        ch_s    = {CHW{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_s = ST_LOAD;
                end
                ST_LOAD: begin
                    // memory data is valid now; capture it at this closing edge
                    load_s  = 1'b1;
                    cnt_s   = {CNTW{1'b0}};
                    state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_s = cnt_r + CNTW'(1'b1);
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_OUT;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (ch_r == CH_LAST) begin
                            state_s = ST_DONE;
                        end else begin
                            ch_s    = ch_r + CHW'(1'b1);
                            state_s = ST_FETCH;
                        end
                    end else begin
                        state_s = ST_OUT;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    ch_s    = {CHW{1'b0}};
                end
            endcase
        end
    end

    // State, channel index and settle counter registers.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_r <= ST_IDLE;
            ch_r    <= {CHW{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            cnt_r   <= cnt_s;
        end
    end

    // Status/strobe outputs are decoded from the next state so that they are
    // registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            p_rd_en_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
            p_rd_en_r   <= (state_s == ST_FETCH);
            out_valid_r <= (state_s == ST_OUT);
        end
    end

    // Filter operands change only on the LOAD edge, keeping the Conv2d result
    // stable for the whole settle and handshake window.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            conv_weight_r <= {WW{1'b0}};
            conv_bias_r   <= {N{1'b0}};
        end else if (load_s) begin
            conv_weight_r <= p_rd_weight;
            conv_bias_r   <= p_rd_bias;
        end else begin
            conv_weight_r <= conv_weight_r;
            conv_bias_r   <= conv_bias_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign p_rd_en     = p_rd_en_r;
    assign p_rd_addr   = ch_r;
    assign out_valid   = out_valid_r;
    assign out_ch      = ch_r;
    assign conv_weight = conv_weight_r;
    assign conv_bias   = conv_bias_r;

endmodule

// File: tb/tb_conv_channel_sched.sv
// Bench for conv_channel_sched: a 4-channel/settle-5 instance and a
// 1-channel/settle-1 instance share one clock, each fed by a small parameter
// memory model. Handshakes are scored against an expected-result queue.
module tb_conv_channel_sched;

    localparam int N        = 8;
    localparam int C        = 1;
    localparam int WW       = 9 * N * C;
    localparam int OUTCH_A  = 4;
    localparam int CHW_A    = 2;
    localparam int SETTLE_A = 5;
    localparam int OUTCH_B  = 1;
    localparam int CHW_B    = 1;
    localparam int SETTLE_B = 1;

    logic clk = 1'b0;
    logic global_rst = 1'b1;

    logic             start_a = 1'b0, abort_a = 1'b0, out_ready_a = 1'b0;
    logic             busy_a, done_a, p_rd_en_a, out_valid_a;
    logic [CHW_A-1:0] p_rd_addr_a, out_ch_a;
    logic [WW-1:0]    mem_w_a = '1, conv_weight_a;
    logic [N-1:0]     mem_b_a = '1, conv_bias_a;

    logic             start_b = 1'b0, abort_b = 1'b0, out_ready_b = 1'b0;
    logic             busy_b, done_b, p_rd_en_b, out_valid_b;
    logic [CHW_B-1:0] p_rd_addr_b, out_ch_b;
    logic [WW-1:0]    mem_w_b = '1, conv_weight_b;
    logic [N-1:0]     mem_b_b = '1, conv_bias_b;

    int total = 0;
    int bad = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    typedef struct {
        int         ch;
        logic [WW-1:0] w;
        logic [N-1:0]  b;
    } sb_t;
    sb_t sb_a[$];
    sb_t sb_b[$];

    typedef struct {
        int               off;
        logic             busy;
        logic             done;
        logic             en;
        logic [CHW_A-1:0] addr;
        logic             ov;
        logic [CHW_A-1:0] och;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    conv_channel_sched #(.N(N), .C(C), .OUTCH(OUTCH_A), .CHW(CHW_A), .SETTLE(SETTLE_A)) dut_a (
        .clk(clk), .global_rst(global_rst), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .p_rd_en(p_rd_en_a), .p_rd_addr(p_rd_addr_a),
        .p_rd_weight(mem_w_a), .p_rd_bias(mem_b_a),
        .conv_weight(conv_weight_a), .conv_bias(conv_bias_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_ch(out_ch_a)
    );

    conv_channel_sched #(.N(N), .C(C), .OUTCH(OUTCH_B), .CHW(CHW_B), .SETTLE(SETTLE_B)) dut_b (
        .clk(clk), .global_rst(global_rst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .p_rd_en(p_rd_en_b), .p_rd_addr(p_rd_addr_b),
        .p_rd_weight(mem_w_b), .p_rd_bias(mem_b_b),
        .conv_weight(conv_weight_b), .conv_bias(conv_bias_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ch(out_ch_b)
    );

    function automatic logic [WW-1:0] exp_w(input int ch);
        logic [N-1:0] v;
        v = N'(ch + 1);
        return {(9 * C){v}};
    endfunction

    function automatic logic [N-1:0] exp_b(input int ch);
        return N'(ch + 16);
    endfunction

    // Parameter memory: data valid the cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        if (p_rd_en_a) begin
            mem_w_a <= exp_w(int'(p_rd_addr_a));
            mem_b_a <= exp_b(int'(p_rd_addr_a));
        end else begin
            mem_w_a <= '1;
            mem_b_a <= '1;
        end
        if (p_rd_en_b) begin
            mem_w_b <= exp_w(int'(p_rd_addr_b));
            mem_b_b <= exp_b(int'(p_rd_addr_b));
        end else begin
            mem_w_b <= '1;
            mem_b_b <= '1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_a_pass();
        for (int i = 0; i < OUTCH_A; i++) begin
            sb_a.push_back('{i, exp_w(i), exp_b(i)});
        end
    endtask

    // One clock: score handshakes/done just before the edge, resume after it.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (out_valid_a && out_ready_a && !abort_a && !global_rst) begin
            if (sb_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL hs_a_extra: actual handshake ch=%0d required none", out_ch_a);
            end else begin
                e = sb_a.pop_front();
                check("hs_a_ch", 128'(out_ch_a), 128'(e.ch));
                check("hs_a_weight", 128'(conv_weight_a), 128'(e.w));
                check("hs_a_bias", 128'(conv_bias_a), 128'(e.b));
            end
        end
        if (out_valid_b && out_ready_b && !abort_b && !global_rst) begin
            if (sb_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL hs_b_extra: actual handshake ch=%0d required none", out_ch_b);
            end else begin
                e = sb_b.pop_front();
                check("hs_b_ch", 128'(out_ch_b), 128'(e.ch));
                check("hs_b_weight", 128'(conv_weight_b), 128'(e.w));
                check("hs_b_bias", 128'(conv_bias_b), 128'(e.b));
            end
        end
        if (done_a && !global_rst) done_cnt_a++;
        if (done_b && !global_rst) done_cnt_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_busy"}, 128'(busy_a), 128'(0));
        check({tag, "_done"}, 128'(done_a), 128'(0));
        check({tag, "_en"}, 128'(p_rd_en_a), 128'(0));
        check({tag, "_addr"}, 128'(p_rd_addr_a), 128'(0));
        check({tag, "_ov"}, 128'(out_valid_a), 128'(0));
        check({tag, "_och"}, 128'(out_ch_a), 128'(0));
        check({tag, "_w"}, 128'(conv_weight_a), 128'(0));
        check({tag, "_b"}, 128'(conv_bias_a), 128'(0));
    endtask

    // Wait (bounded) for a FETCH of the given channel on instance A.
    task automatic wait_fetch_a(input string tag, input logic [CHW_A-1:0] ch);
        int n = 0;
        while (!(p_rd_en_a && p_rd_addr_a == ch) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_reach_fetch"}, 128'(p_rd_en_a && p_rd_addr_a == ch), 128'(1));
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 128'(busy_a), 128'(0));
    endtask

    // One pass of the single-channel, settle-1 instance, checked cycle by cycle.
    task automatic run_b_pass(input string tag);
        sb_b.push_back('{0, exp_w(0), exp_b(0)});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check({tag, "_e0_en"}, 128'(p_rd_en_b), 128'(1));
        check({tag, "_e0_busy"}, 128'(busy_b), 128'(1));
        tick();
        check({tag, "_e1_en"}, 128'(p_rd_en_b), 128'(0));
        check({tag, "_e1_ov"}, 128'(out_valid_b), 128'(0));
        tick();
        check({tag, "_e2_ov"}, 128'(out_valid_b), 128'(0));
        check({tag, "_e2_w"}, 128'(conv_weight_b), 128'(exp_w(0)));
        tick();
        check({tag, "_e3_ov"}, 128'(out_valid_b), 128'(1));
        check({tag, "_e3_och"}, 128'(out_ch_b), 128'(0));
        tick();
        check({tag, "_e4_done"}, 128'(done_b), 128'(1));
        check({tag, "_e4_ov"}, 128'(out_valid_b), 128'(0));
        tick();
        check({tag, "_e5_busy"}, 128'(busy_b), 128'(0));
        check({tag, "_e5_done"}, 128'(done_b), 128'(0));
    endtask

    initial begin
        int idx;
        int n;
        int viol;
        int d0;

        // Nominal pass, offsets counted from the start edge E0.
        //            off busy  done  en    addr  ov    och
        tbl[0]  = '{0,  1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0};
        tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tbl[2]  = '{2,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tbl[3]  = '{6,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tbl[4]  = '{7,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0};
        tbl[5]  = '{8,  1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1};
        tbl[6]  = '{14, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1};
        tbl[7]  = '{15, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1};
        tbl[8]  = '{23, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2};
        tbl[9]  = '{24, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd3};
        tbl[10] = '{31, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3};
        tbl[11] = '{32, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 2'd3};
        tbl[12] = '{33, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'd3};

        // Reset state
        tick();
        tick();
        check_a_zero("rst");
        check("rst_b_busy", 128'(busy_b), 128'(0));
        check("rst_b_ov", 128'(out_valid_b), 128'(0));
        global_rst = 1'b0;
        tick();

        // Nominal pass with out_ready held high
        out_ready_a = 1'b1;
        d0 = done_cnt_a;
        push_a_pass();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        idx = 0;
        for (int k = 0; k <= 33; k++) begin
            while (idx < 13 && tbl[idx].off == k) begin
                check($sformatf("nom%0d_busy", k), 128'(busy_a), 128'(tbl[idx].busy));
                check($sformatf("nom%0d_done", k), 128'(done_a), 128'(tbl[idx].done));
                check($sformatf("nom%0d_en", k), 128'(p_rd_en_a), 128'(tbl[idx].en));
                check($sformatf("nom%0d_addr", k), 128'(p_rd_addr_a), 128'(tbl[idx].addr));
                check($sformatf("nom%0d_ov", k), 128'(out_valid_a), 128'(tbl[idx].ov));
                if (tbl[idx].ov) begin
                    check($sformatf("nom%0d_och", k), 128'(out_ch_a), 128'(tbl[idx].och));
                end
                idx++;
            end
            tick();
        end
        check("nom_sb_left", 128'(sb_a.size()), 128'(0));
        check("nom_done_count", 128'(done_cnt_a - d0), 128'(1));

        // Backpressure in OUT of ch=1
        d0 = done_cnt_a;
        push_a_pass();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_fetch_a("bp", 2'd1);
        out_ready_a = 1'b0;
        n = 0;
        while (!out_valid_a && n < 50) begin
            tick();
            n++;
        end
        check("bp_reach_out", 128'(out_valid_a), 128'(1));
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(out_valid_a && out_ch_a == 2'd1 && conv_weight_a == exp_w(1) && !p_rd_en_a)) viol++;
            tick();
        end
        check("bp_hold_violations", 128'(viol), 128'(0));
        out_ready_a = 1'b1;
        tick();
        check("bp_release_en", 128'(p_rd_en_a), 128'(1));
        check("bp_release_addr", 128'(p_rd_addr_a), 128'(2));
        wait_idle_a("bp");
        check("bp_sb_left", 128'(sb_a.size()), 128'(0));
        check("bp_done_count", 128'(done_cnt_a - d0), 128'(1));

        // start while busy: in WAIT of ch=2, and again during DONE
        d0 = done_cnt_a;
        push_a_pass();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_fetch_a("sb", 2'd2);
        tick();
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 100) begin
            tick();
            n++;
        end
        check("sb_reach_done", 128'(done_a), 128'(1));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("sb_done_start_busy", 128'(busy_a), 128'(0));
        tick();
        check("sb_done_start_busy2", 128'(busy_a), 128'(0));
        check("sb_sb_left", 128'(sb_a.size()), 128'(0));
        check("sb_done_count", 128'(done_cnt_a - d0), 128'(1));

        // Abort in LOAD of ch=2
        d0 = done_cnt_a;
        push_a_pass();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_fetch_a("ab", 2'd2);
        tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("ab_busy", 128'(busy_a), 128'(0));
        check("ab_ov", 128'(out_valid_a), 128'(0));
        check("ab_ch_clear", 128'(p_rd_addr_a), 128'(0));
        check("ab_bias_kept", 128'(conv_bias_a), 128'(exp_b(1)));
        check("ab_weight_kept", 128'(conv_weight_a), 128'(exp_w(1)));
        check("ab_sb_unserved", 128'(sb_a.size()), 128'(2));
        sb_a.delete();
        for (int i = 0; i < 10; i++) tick();
        check("ab_no_done", 128'(done_cnt_a - d0), 128'(0));

        // abort together with start in IDLE
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("ab_idle_start_busy", 128'(busy_a), 128'(0));
        tick();
        check("ab_idle_start_busy2", 128'(busy_a), 128'(0));

        // Reset while out_valid is high, then restart
        out_ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!out_valid_a && n < 50) begin
            tick();
            n++;
        end
        check("rmo_reach_out", 128'(out_valid_a), 128'(1));
        global_rst = 1'b1;
        tick();
        global_rst = 1'b0;
        check_a_zero("rmo");
        out_ready_a = 1'b1;
        push_a_pass();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("rmo_restart_en", 128'(p_rd_en_a), 128'(1));
        check("rmo_restart_addr", 128'(p_rd_addr_a), 128'(0));
        wait_idle_a("rmo");
        check("rmo_sb_left", 128'(sb_a.size()), 128'(0));

        // SETTLE=1, OUTCH=1: two back-to-back passes
        out_ready_b = 1'b1;
        d0 = done_cnt_b;
        run_b_pass("b1");
        run_b_pass("b2");
        check("b_sb_left", 128'(sb_b.size()), 128'(0));
        check("b_done_count", 128'(done_cnt_b - d0), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_channel_sched.md
# conv_channel_sched

Sequencer for the Conv2d datapath. It walks output channels 0..OUTCH-1. For each channel it fetches the weight/bias word pair from parameter memory, holds them stable on the Conv2d filter inputs, waits a fixed settle time, then presents the channel result to a downstream consumer with a valid/ready handshake. It takes over the per-channel weight/bias loading loop that drives a Conv2d instance, so a full layer runs from a single start pulse.

## Interface
Parameters:
- N, 24 — fixed-point word width (Q format handled by Conv2d; this block treats words as opaque bits)
- C, 64 — input channels; weight word is 9*N*C bits
- OUTCH, 128 — number of output channels to sequence; ≥1
- CHW, 7 — channel index width; 2^CHW ≥ OUTCH
- SETTLE, 5 — cycles Conv2d needs after filter inputs change before its result is valid; ≥1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- global_rst  in  1  synchronous active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  cancel the pass in progress
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last channel's handshake
- p_rd_en  out  1  parameter memory read strobe
- p_rd_addr  out  CHW  channel index being read
- p_rd_weight  in  9*N*C  weight word; valid the cycle after p_rd_en
- p_rd_bias  in  N  bias word; valid the cycle after p_rd_en
- conv_weight  out  9*N*C  registered, to Conv2d filterWeight
- conv_bias  out  N  registered, to Conv2d filterBias
- out_valid  out  1  the Conv2d result for out_ch is valid
- out_ready  in  1  consumer accepts the result
- out_ch  out  CHW  channel index of the current result

## Operation
- States: IDLE, FETCH, LOAD, WAIT, OUT, DONE.
- IDLE: if start=1, clear ch to 0 and go to FETCH. Otherwise stay.
- FETCH (1 cycle): p_rd_en=1, p_rd_addr=ch. Go to LOAD.
- LOAD (1 cycle): at the closing edge, register p_rd_weight into conv_weight and p_rd_bias into conv_bias, clear cnt to 0, go to WAIT.
- WAIT: increment cnt each cycle. Leave when cnt reaches SETTLE-1, so WAIT lasts exactly SETTLE cycles. Go to OUT.
- OUT: out_valid=1, out_ch=ch. Hold until out_valid&out_ready at an edge.
  - If ch==OUTCH-1, go to DONE.
  - Otherwise ch←ch+1 and go to FETCH.
- DONE (1 cycle): done=1. Go to IDLE.
- conv_weight/conv_bias change only at the LOAD edge. They stay stable through WAIT and OUT, so the Conv2d result cannot change while out_valid=1.
- p_rd_addr equals ch in all states. p_rd_en is high only in FETCH.
- out_ch equals ch. It is only meaningful while out_valid=1.

## Timing
- Reset: state=IDLE, ch=0, cnt=0. All outputs are 0: busy, done, p_rd_en, p_rd_addr, out_valid, out_ch, conv_weight, conv_bias.
- Start sampled at edge E0:
  - FETCH during E0→E0+1
  - LOAD during E0+1→E0+2
  - out_valid rises at edge E0+2+SETTLE
- Per-channel period with out_ready held high: SETTLE+3 cycles.
- Full pass with out_ready held high: OUTCH*(SETTLE+3) cycles from E0, then a 1-cycle DONE pulse. busy falls on the edge after DONE.
- out_ready backpressure: OUT holds indefinitely. out_valid, out_ch, conv_weight and conv_bias stay frozen.
- out_ready high before OUT has no effect. No transfer happens without out_valid.
- start while busy=1 is ignored, including during DONE.
- abort=1 in any non-IDLE state: next state is IDLE, out_valid and p_rd_en drop on that edge, ch clears to 0, and done does not pulse.
  - conv_weight/conv_bias keep their last value.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins, stay IDLE.
- abort at the same edge as a handshake: abort wins. The consumer must treat that transfer as cancelled.
- global_rst overrides everything at any edge, mid-pass included.
- ch never exceeds OUTCH-1. There is no wrap; the pass ends in DONE.

## Test plan
- Reset mid-OUT (OUTCH=4, SETTLE=5): assert global_rst while out_valid=1 → next cycle all outputs 0, busy=0. A following start restarts at ch=0.
- Nominal pass (OUTCH=4, SETTLE=5, out_ready=1, memory returns weight=ch+1 replicated, bias=ch+0x10):
  - out_valid rises at E0+7 with out_ch=0 and conv_bias=0x10
  - handshakes at E0+7, +15, +23, +31
  - done=1 during E0+32→E0+33; busy=0 after
- Backpressure: hold out_ready=0 for 20 cycles in OUT of ch=1 → out_valid, out_ch=1 and conv_weight are stable for all 20 cycles, with no p_rd_en. Release → p_rd_en appears the next cycle with p_rd_addr=2.
- Start while busy: pulse start at ch=2 WAIT → no restart; channel order stays 0,1,2,3 and there is exactly one done.
- Abort: assert abort in LOAD of ch=2 → IDLE next cycle, out_valid=0, no done, conv_bias keeps the ch=1 value.
- SETTLE=1, OUTCH=1: start → out_valid at E0+3, then done, then IDLE. Back-to-back start on the cycle after busy falls → a second pass completes identically.
